// File: rtl/spi_flash_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// spi_flash_arbiter_pkg : shared state encoding and timing defaults
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package spi_flash_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GRANT0 = 3'd1,
    ST_GRANT1 = 3'd2,
    ST_GUARD  = 3'd3,
    ST_FAULT  = 3'd4
  } arb_state_e;

  localparam int REQ_DSP            = 0;
  localparam int REQ_CPU            = 1;
  localparam int DEF_SYNC_STAGES    = 2;
  localparam int DEF_GUARD_CYCLES   = 16;
  localparam int DEF_TIMEOUT_CYCLES = 1048575;
  localparam int HOLD_CNT_W         = 20;

  function automatic arb_state_e grant_state(input logic owner);
    return owner ? ST_GRANT1 : ST_GRANT0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/spi_flash_arbiter_cs_sync.sv
// ---------------------------------------------------------------------------
// spi_flash_arbiter_cs_sync : chip-select synchroniser, resets to deasserted
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module spi_flash_arbiter_cs_sync
  import spi_flash_arbiter_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic cs_inv_i,
  output logic cs_inv_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  if (SYNC_STAGES == 1) begin : g_single
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        sync_q <= 1'b1;
      end else begin
        sync_q <= cs_inv_i;
      end
    end
  end else begin : g_chain
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        sync_q <= '1;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], cs_inv_i};
      end
    end
  end

  assign cs_inv_o = sync_q[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/spi_flash_arbiter.sv
// ---------------------------------------------------------------------------
// spi_flash_arbiter : shares one SPI flash between DSP and CPU masters;
// hold timeout/FAULT handling enabled by SPI_FLASH_ARB_TIMEOUT_EN. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module spi_flash_arbiter
  import spi_flash_arbiter_pkg::*;
#(
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int GUARD_CYCLES   = DEF_GUARD_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic       sysclk,
  input  logic       reset_INV,
  input  logic       enable,
  input  logic       req0_clk,
  input  logic       req0_mosi,
  input  logic       req0_cs_INV,
  output logic       req0_miso,
  input  logic       req1_clk,
  input  logic       req1_mosi,
  input  logic       req1_cs_INV,
  output logic       req1_miso,
  output logic       flash_clk,
  output logic       flash_mosi,
  output logic       flash_cs_INV,
  input  logic       flash_miso,
  output logic [1:0] gnt,
  output logic       timeout_flag
);

  localparam int GUARD_W = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam logic [GUARD_W-1:0] GUARD_LOAD = GUARD_W'(GUARD_CYCLES - 1);

  logic [1:0] cs_inv_raw;
  logic [1:0] cs_inv_sync;
  logic [1:0] act;
  logic       pick;

  arb_state_e         state_q, state_d;
  logic               last_owner_q, last_owner_d;
  logic [GUARD_W-1:0] guard_q, guard_d;
  logic [1:0]         gnt_q, gnt_d;
`ifdef SPI_FLASH_ARB_TIMEOUT_EN
  logic [HOLD_CNT_W-1:0] hold_q, hold_d;
  logic                  flag_q, flag_d;
`endif

  assign cs_inv_raw = {req1_cs_INV, req0_cs_INV};

  for (genvar i = 0; i < 2; i++) begin : g_sync
    spi_flash_arbiter_cs_sync #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_cs_sync (
      .clk_i   (sysclk),
      .rst_ni  (reset_INV),
      .cs_inv_i(cs_inv_raw[i]),
      .cs_inv_o(cs_inv_sync[i])
    );
  end

  assign act = ~cs_inv_sync;

  // On contention the requester that did not own the bus last goes first.
  assign pick = (act[REQ_DSP] && act[REQ_CPU]) ? ~last_owner_q : act[REQ_CPU];

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    guard_d      = guard_q;
`ifdef SPI_FLASH_ARB_TIMEOUT_EN
    hold_d       = hold_q;
    flag_d       = flag_q;
`endif
    if (!enable) begin
      state_d = ST_IDLE;
      guard_d = '0;
`ifdef SPI_FLASH_ARB_TIMEOUT_EN
      hold_d  = '0;
      flag_d  = 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|act) begin
            state_d      = grant_state(pick);
            last_owner_d = pick;
`ifdef SPI_FLASH_ARB_TIMEOUT_EN
            hold_d       = '0;
`endif
          end
        end
        ST_GRANT0, ST_GRANT1: begin
          // last_owner_q always names the current owner while in a grant state.
          if (!act[last_owner_q]) begin
            state_d = ST_GUARD;
            guard_d = GUARD_LOAD;
`ifdef SPI_FLASH_ARB_TIMEOUT_EN
          end else if (hold_q == HOLD_CNT_W'(TIMEOUT_CYCLES)) begin
            state_d = ST_FAULT;
            flag_d  = 1'b1;
          end else if (hold_q != '1) begin
            hold_d = hold_q + 1'b1;
`endif
          end
        end
        ST_GUARD: begin
          if (guard_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            guard_d = guard_q - 1'b1;
          end
        end
`ifdef SPI_FLASH_ARB_TIMEOUT_EN
        ST_FAULT: begin
          if (!act[last_owner_q]) begin
            state_d = ST_GUARD;
            guard_d = GUARD_LOAD;
          end
        end
`endif
        default: state_d = ST_IDLE;
      endcase
    end
    gnt_d = {state_d == ST_GRANT1, state_d == ST_GRANT0};
  end

  always_ff @(posedge sysclk or negedge reset_INV) begin
    if (!reset_INV) begin
      state_q      <= ST_IDLE;
      last_owner_q <= 1'b1;
      guard_q      <= '0;
      gnt_q        <= 2'b00;
`ifdef SPI_FLASH_ARB_TIMEOUT_EN
      hold_q       <= '0;
      flag_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      guard_q      <= guard_d;
      gnt_q        <= gnt_d;
`ifdef SPI_FLASH_ARB_TIMEOUT_EN
      hold_q       <= hold_d;
      flag_q       <= flag_d;
`endif
    end
  end

  assign gnt = gnt_q;

`ifdef SPI_FLASH_ARB_TIMEOUT_EN
  assign timeout_flag = flag_q;
`else
  assign timeout_flag = 1'b0;
`endif

  always_comb begin
    flash_clk    = 1'b0;
    flash_mosi   = 1'b0;
    flash_cs_INV = 1'b1;
    req0_miso    = 1'b0;
    req1_miso    = 1'b0;
    case (state_q)
      ST_GRANT0: begin
        flash_clk    = req0_clk;
        flash_mosi   = req0_mosi;
        flash_cs_INV = req0_cs_INV;
        req0_miso    = flash_miso;
      end
      ST_GRANT1: begin
        flash_clk    = req1_clk;
        flash_mosi   = req1_mosi;
        flash_cs_INV = req1_cs_INV;
        req1_miso    = flash_miso;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_spi_flash_arbiter.sv
// ---------------------------------------------------------------------------
// tb_spi_flash_arbiter : self-checking bench with a grant-event scoreboard
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_spi_flash_arbiter;

`ifdef SPI_FLASH_ARB_TIMEOUT_EN
  localparam int C_TIMEOUT_CYCLES = 100;
`else
  localparam int C_TIMEOUT_CYCLES = 1048575;
`endif

  logic       sysclk = 1'b0;
  logic       reset_INV = 1'b0;
  logic       enable = 1'b1;
  logic       req0_clk = 1'b0, req0_mosi = 1'b0, req0_cs_INV = 1'b1;
  logic       req1_clk = 1'b0, req1_mosi = 1'b0, req1_cs_INV = 1'b1;
  logic       flash_miso = 1'b0;
  logic       req0_miso, req1_miso;
  logic       flash_clk, flash_mosi, flash_cs_INV;
  logic [1:0] gnt;
  logic       timeout_flag;

  always #5 sysclk = ~sysclk;

  spi_flash_arbiter #(
    .TIMEOUT_CYCLES(C_TIMEOUT_CYCLES)
  ) dut (
    .sysclk      (sysclk),
    .reset_INV   (reset_INV),
    .enable      (enable),
    .req0_clk    (req0_clk),
    .req0_mosi   (req0_mosi),
    .req0_cs_INV (req0_cs_INV),
    .req0_miso   (req0_miso),
    .req1_clk    (req1_clk),
    .req1_mosi   (req1_mosi),
    .req1_cs_INV (req1_cs_INV),
    .req1_miso   (req1_miso),
    .flash_clk   (flash_clk),
    .flash_mosi  (flash_mosi),
    .flash_cs_INV(flash_cs_INV),
    .flash_miso  (flash_miso),
    .gnt         (gnt),
    .timeout_flag(timeout_flag)
  );

  typedef struct {
    logic [1:0] gnt;
    int         cyc;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        mon_ev;
  int         n_checks = 0;
  int         n_fail = 0;
  int         cyc = 0;
  logic       mon_en = 1'b0;
  logic [1:0] gnt_prev = 2'b00;

  always @(posedge sysclk) cyc++;

  // Every change of gnt must match the next expected (value, edge) pair.
  always @(negedge sysclk) begin
    if (!mon_en) begin
      gnt_prev = gnt;
    end else if (gnt !== gnt_prev) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL gnt_event: got gnt=%b at edge %0d, required no change", gnt, cyc);
      end else begin
        mon_ev = exp_q.pop_front();
        if (gnt !== mon_ev.gnt || cyc != mon_ev.cyc) begin
          n_fail++;
          $display("FAIL gnt_event: got gnt=%b at edge %0d, required gnt=%b at edge %0d",
                   gnt, cyc, mon_ev.gnt, mon_ev.cyc);
        end
      end
      gnt_prev = gnt;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  task automatic push_ev(input logic [1:0] g, input int c);
    exp_q.push_back(ev_t'{g, c});
  endtask

  task automatic do_reset();
    mon_en    = 1'b0;
    reset_INV = 1'b0;
    tick(2);
    reset_INV = 1'b1;
    tick(2);
    mon_en    = 1'b1;
  endtask

  task automatic test_reset();
    req0_clk   = 1'b1;
    req0_mosi  = 1'b1;
    flash_miso = 1'b1;
    tick(3);
    n_checks++;
    if (gnt !== 2'b00 || flash_cs_INV !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: gnt=%b cs=%b, required gnt=00 cs=1", gnt, flash_cs_INV);
    end
    n_checks++;
    if ({flash_clk, flash_mosi, req0_miso, req1_miso, timeout_flag} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_pins: clk/mosi/miso0/miso1/flag=%b, required 00000",
               {flash_clk, flash_mosi, req0_miso, req1_miso, timeout_flag});
    end
    req0_clk  = 1'b0;
    req0_mosi = 1'b0;
    reset_INV = 1'b1;
    tick(2);
    mon_en = 1'b1;
  endtask

  task automatic test_single_grant();
    int c0, c1;
    logic [1:0] pat;
    c0 = cyc;
    req0_cs_INV = 1'b0;
    push_ev(2'b01, c0 + 3);
    tick(2);
    n_checks++;
    if (gnt !== 2'b00) begin
      n_fail++;
      $display("FAIL grant_latency_early: gnt=%b after 2 edges, required 00", gnt);
    end
    tick(1);
    for (int i = 0; i < 4; i++) begin
      pat        = i[1:0];
      req0_clk   = pat[0];
      req0_mosi  = pat[1];
      req1_clk   = ~pat[0];
      req1_mosi  = ~pat[1];
      flash_miso = pat[0] ^ pat[1];
      #1;
      n_checks++;
      if ({flash_clk, flash_mosi, flash_cs_INV} !== {pat[0], pat[1], 1'b0}) begin
        n_fail++;
        $display("FAIL pins_mirror_req0: clk/mosi/cs=%b, required %b",
                 {flash_clk, flash_mosi, flash_cs_INV}, {pat[0], pat[1], 1'b0});
      end
      n_checks++;
      if ({req0_miso, req1_miso} !== {pat[0] ^ pat[1], 1'b0}) begin
        n_fail++;
        $display("FAIL miso_route_req0: miso0/miso1=%b, required %b",
                 {req0_miso, req1_miso}, {pat[0] ^ pat[1], 1'b0});
      end
      tick(1);
    end
    c1 = cyc;
    req0_cs_INV = 1'b1;
    req0_clk    = 1'b0;
    req0_mosi   = 1'b0;
    flash_miso  = 1'b1;
    push_ev(2'b00, c1 + 3);
    tick(8);
    n_checks++;
    if (flash_cs_INV !== 1'b1 || req0_miso !== 1'b0) begin
      n_fail++;
      $display("FAIL guard_deselect: cs=%b miso0=%b, required cs=1 miso0=0", flash_cs_INV, req0_miso);
    end
    tick(17);
  endtask

  task automatic test_tie();
    int c0, c1, c2;
    do_reset();
    c0 = cyc;
    req0_cs_INV = 1'b0;
    req1_cs_INV = 1'b0;
    flash_miso  = 1'b1;
    push_ev(2'b01, c0 + 3);
    tick(4);
    n_checks++;
    if ({flash_cs_INV, req0_miso, req1_miso} !== 3'b010) begin
      n_fail++;
      $display("FAIL tie_owner_req0: cs/miso0/miso1=%b, required 010",
               {flash_cs_INV, req0_miso, req1_miso});
    end
    c1 = cyc;
    req0_cs_INV = 1'b1;
    push_ev(2'b00, c1 + 3);
    push_ev(2'b10, c1 + 20);
    tick(10);
    n_checks++;
    if (flash_cs_INV !== 1'b1) begin
      n_fail++;
      $display("FAIL tie_guard_cs: cs=%b while req1 waits, required 1", flash_cs_INV);
    end
    tick(11);
    n_checks++;
    if ({flash_cs_INV, req0_miso, req1_miso} !== 3'b001) begin
      n_fail++;
      $display("FAIL tie_handover_req1: cs/miso0/miso1=%b, required 001",
               {flash_cs_INV, req0_miso, req1_miso});
    end
    c2 = cyc;
    req1_cs_INV = 1'b1;
    push_ev(2'b00, c2 + 3);
    tick(22);
  endtask

  task automatic test_block();
    int c0, c1, c2;
    c0 = cyc;
    req1_cs_INV = 1'b0;
    push_ev(2'b10, c0 + 3);
    tick(4);
    req0_cs_INV = 1'b0;
    tick(6);
    n_checks++;
    if (gnt !== 2'b10) begin
      n_fail++;
      $display("FAIL block_req0: gnt=%b while req1 owns, required 10", gnt);
    end
    req0_clk = 1'b1;
    req1_clk = 1'b0;
    #1;
    n_checks++;
    if ({flash_clk, flash_cs_INV} !== 2'b00) begin
      n_fail++;
      $display("FAIL block_pins_a: clk/cs=%b, required 00 (req1 lines)", {flash_clk, flash_cs_INV});
    end
    req0_clk = 1'b0;
    req1_clk = 1'b1;
    #1;
    n_checks++;
    if ({flash_clk, flash_cs_INV} !== 2'b10) begin
      n_fail++;
      $display("FAIL block_pins_b: clk/cs=%b, required 10 (req1 lines)", {flash_clk, flash_cs_INV});
    end
    tick(1);
    c1 = cyc;
    req1_clk    = 1'b0;
    req1_cs_INV = 1'b1;
    push_ev(2'b00, c1 + 3);
    push_ev(2'b01, c1 + 20);
    tick(21);
    req0_clk = 1'b1;
    #1;
    n_checks++;
    if ({flash_clk, flash_cs_INV} !== 2'b10) begin
      n_fail++;
      $display("FAIL block_release_req0: clk/cs=%b, required 10 (req0 lines)", {flash_clk, flash_cs_INV});
    end
    tick(1);
    c2 = cyc;
    req0_clk    = 1'b0;
    req0_cs_INV = 1'b1;
    push_ev(2'b00, c2 + 3);
    tick(22);
  endtask

  task automatic test_enable();
    int c0, c1, c2, c3;
    c0 = cyc;
    req1_cs_INV = 1'b0;
    push_ev(2'b10, c0 + 3);
    tick(5);
    c1 = cyc;
    enable = 1'b0;
    push_ev(2'b00, c1 + 1);
    #1;
    n_checks++;
    if (flash_cs_INV !== 1'b0) begin
      n_fail++;
      $display("FAIL enable_before_edge: cs=%b, required 0 until next edge", flash_cs_INV);
    end
    tick(1);
    n_checks++;
    if (flash_cs_INV !== 1'b1 || gnt !== 2'b00) begin
      n_fail++;
      $display("FAIL enable_cut: cs=%b gnt=%b, required cs=1 gnt=00", flash_cs_INV, gnt);
    end
    tick(3);
    c2 = cyc;
    enable = 1'b1;
    push_ev(2'b10, c2 + 1);
    tick(1);
    n_checks++;
    if (flash_cs_INV !== 1'b0) begin
      n_fail++;
      $display("FAIL enable_regrant_cs: cs=%b, required 0", flash_cs_INV);
    end
    c3 = cyc;
    req1_cs_INV = 1'b1;
    push_ev(2'b00, c3 + 3);
    tick(22);
  endtask

  task automatic test_async_reset();
    int c0;
    c0 = cyc;
    req0_cs_INV = 1'b0;
    req0_clk    = 1'b1;
    flash_miso  = 1'b1;
    push_ev(2'b01, c0 + 3);
    tick(4);
    #2;
    mon_en    = 1'b0;
    reset_INV = 1'b0;
    #1;
    n_checks++;
    if (gnt !== 2'b00 || flash_cs_INV !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset_gnt: gnt=%b cs=%b, required gnt=00 cs=1", gnt, flash_cs_INV);
    end
    n_checks++;
    if ({flash_clk, req0_miso, timeout_flag} !== 3'b000) begin
      n_fail++;
      $display("FAIL async_reset_pins: clk/miso0/flag=%b, required 000",
               {flash_clk, req0_miso, timeout_flag});
    end
    req0_cs_INV = 1'b1;
    req0_clk    = 1'b0;
    tick(2);
    reset_INV = 1'b1;
    tick(2);
    mon_en = 1'b1;
  endtask

`ifdef SPI_FLASH_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int c0, c2;
    do_reset();
    c0 = cyc;
    req0_cs_INV = 1'b0;
    push_ev(2'b01, c0 + 3);
    push_ev(2'b00, c0 + 104);
    tick(106);
    n_checks++;
    if ({flash_cs_INV, timeout_flag} !== 2'b11) begin
      n_fail++;
      $display("FAIL timeout_fault: cs/flag=%b, required 11", {flash_cs_INV, timeout_flag});
    end
    req0_cs_INV = 1'b1;
    tick(25);
    n_checks++;
    if (timeout_flag !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_sticky: flag=%b, required 1", timeout_flag);
    end
    c2 = cyc;
    req0_cs_INV = 1'b0;
    push_ev(2'b01, c2 + 3);
    tick(4);
    n_checks++;
    if (timeout_flag !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_sticky_regrant: flag=%b, required 1", timeout_flag);
    end
    req0_cs_INV = 1'b1;
    do_reset();
    n_checks++;
    if (timeout_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_reset_clear: flag=%b, required 0", timeout_flag);
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_grant();
    test_tie();
    test_block();
    test_enable();
    test_async_reset();
`ifdef SPI_FLASH_ARB_TIMEOUT_EN
    test_timeout();
`endif
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d grant events never seen, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
